// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a qualifier, overlap/non-overlap
// modes and a saturating match counter. Reset defaults give an overlapping 1011 detector.
module seq_detector_param #(
    parameter int          MAX_LEN     = 8,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] DEF_PATTERN = 32'b1011,
    parameter int          DEF_LEN     = 4,
    parameter bit          DEF_OVERLAP = 1'b1,
    localparam int         LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_valid,
    input  logic               seq_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detect_out,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               fresh_q, fresh_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic pat_eq;
    logic match;

    // A load strobe owns the edge: any bit offered alongside it is dropped.
    assign accept = seq_valid && !cfg_load;

    // Only the newest len_q history bits take part in the comparison.
    always_comb begin
        pat_eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (hist_q[i] != pat_q[i])) begin
                pat_eq = 1'b0;
            end
        end
        match = fresh_q && (fill_q == len_q) && pat_eq;
    end

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        fresh_d  = accept;
        detect_d = match;
        cnt_d    = cnt_q;

        if (accept) begin
            hist_d = {hist_q[MAX_LEN-2:0], seq_in};
        end

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            len_d  = ((cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN))) ? LEN_W'(MAX_LEN) : cfg_len;
            fill_d = '0;
        end else if (match && !ovl_q) begin
            // Non-overlap: the next match may only use bits after the matched one.
            fill_d = accept ? LEN_W'(1) : '0;
        end else if (accept && (fill_q < len_q)) begin
            fill_d = fill_q + LEN_W'(1);
        end

        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q    <= DEF_PATTERN[MAX_LEN-1:0];
            len_q    <= LEN_W'(DEF_LEN);
            ovl_q    <= DEF_OVERLAP;
            hist_q   <= '0;
            fill_q   <= '0;
            fresh_q  <= 1'b0;
            detect_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            fresh_q  <= fresh_d;
            detect_q <= detect_d;
            cnt_q    <= cnt_d;
        end
    end

    assign detect_out  = detect_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic, compared each
// cycle against a queue-based model of the received bit window.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               reset;
    logic               seq_valid;
    logic               seq_in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               detect_out;
    logic [CNT_W-1:0]   match_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: the bits eligible to form the next match, oldest first.
    bit               win[$];
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_pend;
    int               m_cnt;
    bit               exp_det;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seq_valid  (seq_valid),
        .seq_in     (seq_in),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .count_clr  (count_clr),
        .detect_out (detect_out),
        .match_count(match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_pat   = 8'b1011;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_pend  = 1'b0;
        m_cnt   = 0;
        exp_det = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit d, input bit ld, input logic [MAX_LEN-1:0] pat,
                              input logic [LEN_W-1:0] len, input bit ovl, input bit clr);
        bit hit;
        exp_det = m_pend;
        if (clr)
            m_cnt = 0;
        else if (m_pend && m_cnt < CNT_MAX)
            m_cnt++;
        m_pend = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = (len == 0 || int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
            m_ovl = ovl;
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > MAX_LEN) void'(win.pop_front());
            hit = 1'b0;
            if (win.size() >= m_len) begin
                hit = 1'b1;
                // Pattern bit j must equal the bit received j positions before the newest.
                for (int j = 0; j < m_len; j++)
                    if (win[win.size() - 1 - j] != m_pat[j]) hit = 1'b0;
            end
            if (hit) begin
                m_pend = 1'b1;
                if (!m_ovl) win.delete();
            end
        end
    endtask

    // Called at a falling edge; drives one edge of stimulus and checks both outputs.
    task automatic drive(input bit v, input bit d, input bit ld, input logic [MAX_LEN-1:0] pat,
                         input logic [LEN_W-1:0] len, input bit ovl, input bit clr);
        seq_valid   = v;
        seq_in      = d;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        count_clr   = clr;
        @(posedge clk);
        model_edge(v, d, ld, pat, len, ovl, clr);
        @(negedge clk);
        check("detect_out", detect_out, exp_det);
        check("match_count", match_count, m_cnt);
    endtask

    task automatic bit_in(input bit d);
        drive(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
        drive(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
    endtask

    task automatic clear_count();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check("reset_detect", detect_out, 1'b0);
        check("reset_count", match_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        seq_valid   = 1'b0;
        seq_in      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;
        model_reset();
        @(negedge clk);
        check("por_detect", detect_out, 1'b0);
        check("por_count", match_count, 0);
        reset = 1'b0;

        // Reset configuration: overlapping 1011.
        send(32'b1011011, 7);
        idle(2);
        check("plan_overlap_count", match_count, 2);

        // Non-overlapping 1011 on the same stream.
        load(8'b1011, 4, 1'b0);
        clear_count();
        send(32'b1011011, 7);
        idle(2);
        check("plan_nonoverlap_count", match_count, 1);

        // Valid gaps between bits: one pulse, no repeat while idle.
        load(8'b1011, 4, 1'b1);
        clear_count();
        for (int i = 3; i >= 0; i--) begin
            bit_in(4'b1011 >> i);
            idle(3);
        end
        check("plan_gaps_count", match_count, 1);

        // Length 1, then counter saturation and clear priority.
        load(8'b1, 1, 1'b1);
        clear_count();
        send(32'b111, 3);
        idle(2);
        check("plan_len1_count", match_count, 3);
        send(32'b11, 2);
        idle(2);
        check("plan_saturate", match_count, 3);
        bit_in(1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("plan_clr_priority", match_count, 0);
        idle(2);

        // Load coincident with a valid bit drops that bit.
        clear_count();
        drive(1'b1, 1'b1, 1'b1, 8'b1, 1, 1'b1, 1'b0);
        idle(2);
        check("plan_load_drops_bit", match_count, 0);

        // Reset mid-sequence discards the partial pattern.
        load(8'b1011, 4, 1'b1);
        send(32'b101, 3);
        do_reset();
        bit_in(1'b1);
        idle(2);
        check("plan_reset_nodetect", match_count, 0);
        send(32'b011, 3);
        idle(2);
        check("plan_reset_then_match", match_count, 1);

        // Length 0 clamps to MAX_LEN: only the full 8-bit pattern matches.
        load(8'b1001_0110, 0, 1'b1);
        clear_count();
        send(32'b1001_0110, 8);
        idle(2);
        check("plan_len0_clamp", match_count, 1);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_reset();
            end else if (r < 5) begin
                logic [LEN_W-1:0] l;
                l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                : LEN_W'($urandom_range(1, 3));
                drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b1,
                      MAX_LEN'($urandom), l, ($urandom_range(0, 1) == 1), 1'b0);
            end else begin
                drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), 1'b0,
                      MAX_LEN'($urandom), LEN_W'($urandom), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 39) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
